sii_sync_filter: RTL and testbench

//   Parametrised multi-bit synchroniser for asynchronous inputs (pins, other clock domains).

---
 rtl/sii_sync_filter.sv | 79 +++++++
 tb/tb_sii_sync_filter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sii_sync_filter.sv
// Per-bit multi-flop synchroniser followed by a stability filter and edge pulses.
// Every bit is independent; do not use it for buses that must change coherently.
module sii_sync_filter #(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] data_filt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    if (STAGES < 2) begin : g_stages_chk
        $error("sii_sync_filter: STAGES must be at least 2");
    end
    if (FILT_CNT < 1 || FILT_CNT > 65535) begin : g_filt_chk
        $error("sii_sync_filter: FILT_CNT must be in 1..65535");
    end

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [STAGES-1:0] chain_reg;
        logic [CW-1:0]     cnt_reg;
        logic              filt_reg;
        logic              rise_reg;
        logic              fall_reg;
        logic              sync_bit;
        logic              differ;
        logic              update;

        // Pure flop chain: stage 0 feeds only stage 1, nothing else touches it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_reg <= {STAGES{RST_VAL[gi]}};
            end else begin
                chain_reg <= {chain_reg[STAGES-2:0], data_in[gi]};
            end
        end

        assign sync_bit = chain_reg[STAGES-1];
        assign differ   = sync_bit ^ filt_reg;
        assign update   = differ && (cnt_reg == CNT_LAST);

        // Any cycle where the synchronised value agrees with the output restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg  <= '0;
                filt_reg <= RST_VAL[gi];
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
            end else begin
                rise_reg <= update & sync_bit;
                fall_reg <= update & ~sync_bit;
                if (!differ) begin
                    cnt_reg <= '0;
                end else if (update) begin
                    filt_reg <= sync_bit;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign data_sync[gi] = sync_bit;
        assign data_filt[gi] = filt_reg;
        assign rise[gi]      = rise_reg;
        assign fall[gi]      = fall_reg;
    end

endmodule

// File: tb/tb_sii_sync_filter.sv
// Directed and randomised checks of sii_sync_filter against a sliding-window
// reference model (WIDTH=4, STAGES=2, FILT_CNT=4) plus a STAGES=3/FILT_CNT=1 instance.
module tb_sii_sync_filter;

    localparam int W = 4;
    localparam int S = 2;
    localparam int F = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] data_in = 4'h0;
    logic [W-1:0] data_sync, data_filt, rise, fall;
    logic [W-1:0] data_in_b = 4'hA;
    logic [W-1:0] sync_b, filt_b, rise_b, fall_b;

    int n_checks = 0;
    int n_errors = 0;
    bit model_chk_en = 1'b0;

    always #5 clk = ~clk;

    sii_sync_filter #(.WIDTH(W), .STAGES(S), .FILT_CNT(F), .RST_VAL(4'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_sync(data_sync), .data_filt(data_filt), .rise(rise), .fall(fall)
    );

    sii_sync_filter #(.WIDTH(W), .STAGES(3), .FILT_CNT(1), .RST_VAL(4'hA)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in_b),
        .data_sync(sync_b), .data_filt(filt_b), .rise(rise_b), .fall(fall_b)
    );

    // Reference: data_sync is the input from S edges back; data_filt flips a bit once the
    // last F synchronised samples since reset have all disagreed with it.
    logic [W-1:0] m_chain [S];
    logic [W-1:0] m_hist  [F];
    int           m_valid;
    logic [W-1:0] m_filt, m_rise, m_fall;

    function automatic logic [W-1:0] win_upd(input logic [W-1:0] snow);
        logic [W-1:0] u;
        if (m_valid < F - 1) return '0;
        u = snow ^ m_filt;
        for (int k = 0; k < F - 1; k++) u &= m_hist[k] ^ m_filt;
        return u;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) m_chain[k] <= '0;
            for (int k = 0; k < F; k++) m_hist[k] <= '0;
            m_valid <= 0;
            m_filt  <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
        end else begin
            m_rise  <= win_upd(m_chain[S-1]) & m_chain[S-1];
            m_fall  <= win_upd(m_chain[S-1]) & ~m_chain[S-1];
            m_filt  <= m_filt ^ win_upd(m_chain[S-1]);
            m_hist[0] <= m_chain[S-1];
            for (int k = 1; k < F; k++) m_hist[k] <= m_hist[k-1];
            m_valid <= (m_valid < F) ? m_valid + 1 : m_valid;
            m_chain[0] <= data_in;
            for (int k = 1; k < S; k++) m_chain[k] <= m_chain[k-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_chk_en) begin
            chk("model_sync", 32'(data_sync), 32'(m_chain[S-1]));
            chk("model_filt", 32'(data_filt), 32'(m_filt));
            chk("model_rise", 32'(rise), 32'(m_rise));
            chk("model_fall", 32'(fall), 32'(m_fall));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found, seen_rise, seen_fall;
        int rise_at, fall_at;

        // 1. Asynchronous reset with all inputs high.
        data_in = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sync", 32'(data_sync), 32'h0);
        chk("rst_filt", 32'(data_filt), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_b_sync", 32'(sync_b), 32'hA);
        chk("rst_b_filt", 32'(filt_b), 32'hA);
        chk("rst_b_edges", 32'({rise_b, fall_b}), 32'h0);
        model_chk_en = 1'b1;
        tick(2);
        data_in = 4'h0;
        rst_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("rel_no_pulse", 32'({rise, fall}), 32'h0);
        end

        // 2. Step on bit 0.
        data_in = 4'b0001;
        tick(1);
        chk("step_sync_E", 32'(data_sync), 32'h0);
        tick(1);
        chk("step_sync_E1", 32'(data_sync), 32'h1);
        tick(3);
        chk("step_filt_E4", 32'(data_filt), 32'h0);
        tick(1);
        chk("step_filt_E5", 32'(data_filt), 32'h1);
        chk("step_rise_E5", 32'(rise), 32'h1);
        tick(1);
        chk("step_rise_E6", 32'(rise), 32'h0);
        chk("step_filt_E6", 32'(data_filt), 32'h1);

        // 3. Glitches on bit 1: 3 cycles rejected, 4 cycles accepted.
        data_in = 4'b0011;
        tick(3);
        data_in = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (data_filt[1] || rise[1] || fall[1]) found = 1'b1;
        end
        chk("glitch3_quiet", 32'(found), 32'h0);
        data_in = 4'b0011;
        tick(4);
        data_in = 4'b0001;
        seen_rise = 1'b0; seen_fall = 1'b0; rise_at = 0; fall_at = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (rise[1] && !seen_rise) begin seen_rise = 1'b1; rise_at = i; end
            if (fall[1] && !seen_fall) begin seen_fall = 1'b1; fall_at = i; end
        end
        chk("glitch4_rise", 32'(seen_rise), 32'h1);
        chk("glitch4_fall", 32'(seen_fall), 32'h1);
        chk("glitch4_order", 32'(fall_at - rise_at), 32'd4);

        // 4. Simultaneous rise on bit 3 and fall on bit 2.
        data_in = 4'b0100;
        tick(12);
        chk("simul_pre", 32'(data_filt), 32'h4);
        data_in = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            if (rise[3]) begin
                found = 1'b1;
                chk("simul_fall2", 32'(fall), 32'b0100);
                chk("simul_filt", 32'(data_filt), 32'b1000);
            end
        end
        chk("simul_seen", 32'(found), 32'h1);

        // 5. Reset in the middle of counting a bit-0 change.
        tick(2);
        data_in = 4'b1001;
        tick(4);
        #2;
        rst_n   = 1'b0;
        data_in = 4'h0;
        #1;
        chk("midrst_out", 32'({data_sync, data_filt, rise, fall}), 32'h0);
        tick(2);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rise != 0 || fall != 0 || data_filt != 0) found = 1'b1;
        end
        chk("midrst_quiet", 32'(found), 32'h0);

        // Randomised traffic checked by the reference model every cycle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) data_in[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) data_in = W'($urandom);
            tick(1);
        end

        // 6. STAGES=3, FILT_CNT=1, RST_VAL=A instance.
        data_in_b = 4'h5;
        tick(3);
        chk("b_filt_E2", 32'(filt_b), 32'hA);
        tick(1);
        chk("b_filt_E3", 32'(filt_b), 32'h5);
        chk("b_rise_E3", 32'(rise_b), 32'h5);
        chk("b_fall_E3", 32'(fall_b), 32'hA);
        tick(1);
        chk("b_edges_E4", 32'({rise_b, fall_b}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
